clk_div_multi: RTL

Parametrised multi-channel clock divider: derives `CHANNELS` independent, 50%-duty divided clocks from the board clock `clk_in`. Each channel's divisor is runtime-programmable and changes glitch-free at a period boundary. Each channel has an enable and a single-cycle rising-edge tick. It sits at the top level beside the processor and feeds the display-refresh, debounce and single-step clock domains. A reset-loaded default of 100,000 input cycles per half period gives 500 Hz from 100 MHz.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_multi_if.sv | 39 +++
 rtl/clk_div_channel.sv | 99 +++++++++
 rtl/clk_div_multi.sv | 55 +++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned F_IN_HZ = 100_000_000;
    localparam int unsigned CNT_W   = 32;

    typedef logic [CNT_W-1:0] half_t;

    // Half-period count in clk_in cycles for a wanted output frequency.
    function automatic half_t half_count(input int unsigned f_out_hz);
        return half_t'(F_IN_HZ / (2 * f_out_hz));
    endfunction

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle of clk_div_multi; sync_start exists only with CLK_DIV_SYNC_EN.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 32
);
    localparam int unsigned SEL_W = sel_width(CHANNELS);

    logic [CHANNELS-1:0] ch_en;
    logic                div_wr;
    logic [SEL_W-1:0]    div_sel;
    logic [CNT_W-1:0]    div_half;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] div_pending;
`ifdef CLK_DIV_SYNC_EN
    logic                sync_start;

    modport master (
        output ch_en, div_wr, div_sel, div_half, sync_start,
        input  clk_out, tick, div_pending
    );
    modport slave (
        input  ch_en, div_wr, div_sel, div_half, sync_start,
        output clk_out, tick, div_pending
    );
`else
    modport master (
        output ch_en, div_wr, div_sel, div_half,
        input  clk_out, tick, div_pending
    );
    modport slave (
        input  ch_en, div_wr, div_sel, div_half,
        output clk_out, tick, div_pending
    );
`endif

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, divisor shadow, enable/stop handling.
// Optional CLK_DIV_SYNC_EN adds the sync input.
module clk_div_channel #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = 100000
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] half_eff;
    logic             at_end;
    logic             running;
    logic             sync_hit;
    logic             commit;

    // The stopping state is implicit: a high output keeps counting until its
    // falling toggle whatever en does, so running = en | clk_q covers it.
    always_comb begin
        half_eff = (active_q == '0) ? CNT_W'(1) : active_q;
        at_end   = (cnt_q == half_eff - CNT_W'(1));
        running  = en | clk_q;
`ifdef CLK_DIV_SYNC_EN
        sync_hit = sync & running;
`else
        sync_hit = 1'b0;
`endif

        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (sync_hit || !running) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (at_end) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Divisor only changes at a period end or while idle; a same-edge write wins.
        commit      = sync_hit | ~running | (at_end & clk_q);
        active_d    = active_q;
        pend_half_d = pend_half_q;
        pend_d      = pend_q;
        if (commit) begin
            pend_d = 1'b0;
            if (wr) begin
                active_d = wr_half;
            end else if (pend_q) begin
                active_d = pend_half_q;
            end
        end else if (wr) begin
            pend_half_d = wr_half;
            pend_d      = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            active_q    <= CNT_W'(DEFAULT_HALF);
            pend_half_q <= '0;
            pend_q      <= 1'b0;
            clk_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            pend_half_q <= pend_half_d;
            pend_q      <= pend_d;
            clk_q       <= clk_d;
            tick_q      <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel 50%-duty clock divider with runtime divisors; top-level select
// decode and channel fan-out. Optional CLK_DIV_SYNC_EN adds bus.sync_start.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = half_count(500)
) (
    input  logic          clk_in,
    input  logic          reset,
    clk_div_multi_if.slave bus
);

    localparam int unsigned SEL_W = sel_width(CHANNELS);

    logic [CHANNELS-1:0] wr_vec;
    logic [CHANNELS-1:0] clk_w;
    logic [CHANNELS-1:0] tick_w;
    logic [CHANNELS-1:0] pend_w;

    // Selects beyond CHANNELS match no channel, so such writes are dropped.
    always_comb begin
        wr_vec = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (bus.div_wr && (bus.div_sel == SEL_W'(c))) begin
                wr_vec[c] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        clk_div_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk_in  (clk_in),
            .reset   (reset),
            .en      (bus.ch_en[g]),
            .wr      (wr_vec[g]),
            .wr_half (bus.div_half),
`ifdef CLK_DIV_SYNC_EN
            .sync    (bus.sync_start),
`endif
            .clk_out (clk_w[g]),
            .tick    (tick_w[g]),
            .pending (pend_w[g])
        );
    end

    assign bus.clk_out     = clk_w;
    assign bus.tick        = tick_w;
    assign bus.div_pending = pend_w;

endmodule
